// File: rtl/lab5_pkg.sv
// lab5_pkg
// Shared definitions for the counter pacing logic.
//   RATE_*     : encodings of the 2-bit rate select
//   rate_load  : reload value of the pacing down-counter for a given rate
//                select and input clock frequency. A counter loaded with
//                L counts L+1 cycles between pulses.
package lab5_pkg;

    localparam logic [1:0] RATE_FULL    = 2'd0;  // pulse every cycle
    localparam logic [1:0] RATE_1HZ     = 2'd1;
    localparam logic [1:0] RATE_HALF    = 2'd2;  // 0.5 Hz
    localparam logic [1:0] RATE_QUARTER = 2'd3;  // 0.25 Hz

    // Returned 64 bits wide; callers truncate to their counter width after
    // the elaboration check has proven the largest value fits.
    function automatic logic [63:0] rate_load(input logic [1:0] sel,
                                              input logic [63:0] clock_hz);
        logic [63:0] load;
        case (sel)
            RATE_FULL:    load = 64'd0;
            RATE_1HZ:     load = clock_hz - 64'd1;
            RATE_HALF:    load = (clock_hz << 1) - 64'd1;
            RATE_QUARTER: load = (clock_hz << 2) - 64'd1;
            default:      load = 64'd0;
        endcase
        return load;
    endfunction

endpackage

// File: rtl/rate_enable_gen_rising_edge_det.sv
// rising_edge_det
// Rising-edge detector for a level input that is already synchronous to
// Clock. Produces a combinational one-cycle strobe on the first cycle the
// input is seen high; the caller registers it.
//   Clock  : clock, posedge active
//   Resetn : asynchronous active-low reset (history cleared to 0)
//   D      : level input
//   Pulse  : D & ~(D from previous cycle)
module rising_edge_det (
    input  logic Clock,
    input  logic Resetn,
    input  logic D,
    output logic Pulse
);

    logic d_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= D;
        end
    end

    assign Pulse = D & ~d_q;

endmodule

// File: rtl/rate_enable_gen.sv
// rate_enable_gen
// Pacing stage for the 8-bit counter: divides Clock down to a selectable
// rate and emits a registered one-cycle Enable pulse. Supports pause and
// single-step from a push-button.
//   Clock  : clock, all state updates on posedge
//   Resetn : asynchronous active-low reset
//   Sel    : rate select (0 every cycle, 1 = 1 Hz, 2 = 0.5 Hz, 3 = 0.25 Hz)
//   Run    : 1 free-running, 0 paused (Step then advances by one)
//   Step   : synchronous level; each rising edge gives one pulse while paused
//   Enable : registered one-cycle pulse to the downstream counter
//   Count  : current down-counter value, for visibility
module rate_enable_gen
    import lab5_pkg::*;
#(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int CW       = $clog2(4 * CLOCK_HZ)
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic [1:0]    Sel,
    input  logic          Run,
    input  logic          Step,
    output logic          Enable,
    output logic [CW-1:0] Count
);

    localparam logic [63:0] HZ64     = 64'(CLOCK_HZ);
    localparam logic [63:0] MAX_LOAD = (HZ64 << 2) - 64'd1;

    // The slowest reload value has to fit the counter, otherwise the
    // truncations below would silently shorten the period.
    generate
        if (CW < 1 || (CW < 64 && MAX_LOAD >= (64'd1 << CW))) begin : g_cw_check
            $fatal(1, "rate_enable_gen: CW=%0d too narrow for CLOCK_HZ=%0d", CW, CLOCK_HZ);
        end
    endgenerate

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [1:0]    sel_q;
    logic          enable_nxt;
    logic          step_rise;
    logic [CW-1:0] load_new;
    logic [CW-1:0] load_cur;

    rising_edge_det u_step_edge (
        .Clock  (Clock),
        .Resetn (Resetn),
        .D      (Step),
        .Pulse  (step_rise)
    );

    assign load_new = CW'(rate_load(Sel, HZ64));
    assign load_cur = CW'(rate_load(sel_q, HZ64));

    // Rate change outranks Run and Step so a new rate always starts from a
    // clean reload with no stray pulse. The step edge detector keeps
    // tracking Step in every branch, so an edge seen while running is
    // consumed rather than replayed at the next pause.
    always_comb begin
        count_nxt  = count;
        enable_nxt = 1'b0;
        if (Sel != sel_q) begin
            count_nxt = load_new;
        end else if (Run) begin
            if (count == '0) begin
                enable_nxt = 1'b1;
                count_nxt  = load_cur;
            end else begin
                count_nxt = count - CW'(1);
            end
        end else begin
            enable_nxt = step_rise;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count  <= '0;
            sel_q  <= RATE_FULL;
            Enable <= 1'b0;
        end else begin
            count  <= count_nxt;
            sel_q  <= Sel;
            Enable <= enable_nxt;
        end
    end

    assign Count = count;

endmodule

// File: tb/tb_rate_enable_gen.sv
module tb_rate_enable_gen;

    localparam int HZ = 4;
    localparam int CW = $clog2(4 * HZ);

    typedef struct packed {
        logic          en;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [1:0]    sel;
    logic          run;
    logic          step;
    logic          enable;
    logic [CW-1:0] count;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    rate_enable_gen #(.CLOCK_HZ(HZ), .CW(CW)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .Sel    (sel),
        .Run    (run),
        .Step   (step),
        .Enable (enable),
        .Count  (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic en, input int cnt);
        exp_t e;
        e.en  = en;
        e.cnt = cnt[CW-1:0];
        sb.push_back(e);
    endtask

    // Leaves the bench at a negedge with reset released and inputs applied.
    task automatic apply_reset(input logic [1:0] s, input logic r, input logic st);
        rst_n = 1'b0;
        sel   = s;
        run   = r;
        step  = st;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        sel   = 2'd0;
        run   = 1'b1;
        step  = 1'b0;
        #1;
        push(1'b0, 0);
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || count !== e.cnt) begin
            failures++;
            $display("FAIL reset_async: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                     enable, count, e.en, e.cnt);
        end
        push(1'b0, 0);
        push(1'b0, 0);
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL reset_hold: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         enable, count, e.en, e.cnt);
            end
        end
    endtask

    task automatic test_rate_1hz();
        exp_t e;
        int   n;
        apply_reset(2'd1, 1'b1, 1'b0);
        push(0, 3); push(0, 2); push(0, 1); push(0, 0); push(1, 3);
        push(0, 2); push(0, 1); push(0, 0); push(1, 3); push(0, 2);
        n = 0;
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL rate_1hz[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
    endtask

    task automatic test_rate_full();
        exp_t e;
        int   n;
        apply_reset(2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) push(1, 0);
        n = 0;
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL rate_full[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
    endtask

    task automatic test_rate_change();
        exp_t e;
        int   n;
        apply_reset(2'd3, 1'b1, 1'b0);
        for (int v = 15; v >= 9; v--) push(0, v);
        n = 0;
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL rate_change_pre[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
        sel = 2'd1;
        push(0, 3); push(0, 2); push(0, 1); push(0, 0); push(1, 3);
        n = 0;
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL rate_change_post[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
    endtask

    task automatic test_pause();
        exp_t e;
        int   n;
        apply_reset(2'd1, 1'b1, 1'b0);
        push(0, 3); push(0, 2);
        for (int i = 0; i < 10; i++) push(0, 2);
        push(0, 1); push(0, 0); push(1, 3);
        n = 0;
        while (sb.size() != 0) begin
            if (n == 2)  run = 1'b0;
            if (n == 12) run = 1'b1;
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL pause[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
    endtask

    task automatic test_step();
        exp_t       e;
        int         n;
        logic [1:0] sel_seq  [$];
        logic       run_seq  [$];
        logic       step_seq [$];
        apply_reset(2'd1, 1'b0, 1'b0);
        // Each row: Sel, Run, Step driven before the edge, then expectation.
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(0); push(0, 3);
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(0); push(0, 3);
        // Step held high for 5 cycles: one pulse only.
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(1); push(1, 3);
        for (int i = 0; i < 4; i++) begin
            sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(1); push(0, 3);
        end
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(0); push(0, 3);
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(0); push(0, 3);
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(1); push(1, 3);
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(0); push(0, 3);
        // Running: Step edges are ignored, counter paces normally.
        sel_seq.push_back(1); run_seq.push_back(1); step_seq.push_back(1); push(0, 2);
        sel_seq.push_back(1); run_seq.push_back(1); step_seq.push_back(0); push(0, 1);
        sel_seq.push_back(1); run_seq.push_back(1); step_seq.push_back(1); push(0, 0);
        sel_seq.push_back(1); run_seq.push_back(1); step_seq.push_back(0); push(1, 3);
        // Step high across Run 1->0: no pulse.
        sel_seq.push_back(1); run_seq.push_back(1); step_seq.push_back(1); push(0, 2);
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(1); push(0, 2);
        sel_seq.push_back(1); run_seq.push_back(0); step_seq.push_back(0); push(0, 2);
        // Step edge together with a rate change: rate change wins.
        sel_seq.push_back(2); run_seq.push_back(0); step_seq.push_back(1); push(0, 7);
        sel_seq.push_back(2); run_seq.push_back(0); step_seq.push_back(1); push(0, 7);
        sel_seq.push_back(2); run_seq.push_back(0); step_seq.push_back(0); push(0, 7);
        n = 0;
        while (sb.size() != 0) begin
            sel  = sel_seq.pop_front();
            run  = run_seq.pop_front();
            step = step_seq.pop_front();
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL step[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   n;
        apply_reset(2'd1, 1'b1, 1'b0);
        push(0, 3); push(0, 2); push(0, 1); push(0, 0); push(1, 3);
        n = 0;
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL areset_pre[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
        // Pulse is high now; drop reset between edges.
        #2 rst_n = 1'b0;
        #1;
        push(0, 0);
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || count !== e.cnt) begin
            failures++;
            $display("FAIL areset_immediate: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                     enable, count, e.en, e.cnt);
        end
        tick();
        push(0, 0);
        e = sb.pop_front();
        checks++;
        if (enable !== e.en || count !== e.cnt) begin
            failures++;
            $display("FAIL areset_held: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                     enable, count, e.en, e.cnt);
        end
        rst_n = 1'b1;
        push(0, 3); push(0, 2); push(0, 1); push(0, 0); push(1, 3); push(0, 2);
        n = 0;
        while (sb.size() != 0) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (enable !== e.en || count !== e.cnt) begin
                failures++;
                $display("FAIL areset_post[%0d]: Enable=%0b Count=%0d, expected Enable=%0b Count=%0d",
                         n, enable, count, e.en, e.cnt);
            end
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 2'd0;
        run   = 1'b0;
        step  = 1'b0;
        @(negedge clk);
        test_reset();
        test_rate_1hz();
        test_rate_full();
        test_rate_change();
        test_pause();
        test_step();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
